// File: rtl/store_write_buffer.sv
// Store write buffer: FIFO of CPU stores draining to data memory, with youngest-match load forwarding.
// Define WB_COALESCE_EN to merge a store into a matching buffered entry instead of allocating a new one.
module store_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_enable,
   input  logic              i_write_enable,
   input  logic [ADDR_W-1:0] i_write_address,
   input  logic [DATA_W-1:0] i_write_data,
   input  logic [ADDR_W-1:0] i_read_address,
   output logic [DATA_W-1:0] o_read_data,
   output logic              o_fwd_hit,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_overflow,
   output logic [ADDR_W-1:0] o_mem_read_address,
   input  logic [DATA_W-1:0] i_mem_read_data,
   output logic              o_mem_write_enable,
   output logic [ADDR_W-1:0] o_mem_write_address,
   output logic [DATA_W-1:0] o_mem_write_data,
   input  logic              i_mem_write_ready
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;

   logic              pop, push, coalesce;
   logic [PW-1:0]     coal_idx, fwd_idx;
   logic              fwd_match;
   logic [DEPTH-1:0]  rd_match;
   logic [PW-1:0]     age_idx [DEPTH];

   assign o_empty    = (count_q == '0);
   assign o_full     = (count_q == CW'(DEPTH));
   assign o_overflow = overflow_q;

   assign o_mem_read_address  = i_read_address;
   assign o_mem_write_enable  = clk_enable && !o_empty;
   assign o_mem_write_address = o_empty ? '0 : addr_q[head_q];
   assign o_mem_write_data    = o_empty ? '0 : data_q[head_q];

   assign pop = o_mem_write_enable && i_mem_write_ready;

   // age_idx[k] is the slot k positions younger than the head, so scanning k upward ends on the youngest
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
         assign age_idx[gi]  = head_q + PW'(gi);
         assign rd_match[gi] = valid_q[gi] && (addr_q[gi] == i_read_address);
      end
   endgenerate

   always_comb begin
      fwd_match = 1'b0;
      fwd_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (rd_match[age_idx[k]]) begin
            fwd_match = 1'b1;
            fwd_idx   = age_idx[k];
         end
      end
   end

   assign o_fwd_hit   = fwd_match;
   assign o_read_data = fwd_match ? data_q[fwd_idx] : i_mem_read_data;

`ifdef WB_COALESCE_EN
   logic [DEPTH-1:0] wr_match;
   logic             coal_hit;

   // The head slot leaving this cycle cannot absorb a store; it would be lost with the pop
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_coal
         assign wr_match[gi] = valid_q[gi] && (addr_q[gi] == i_write_address)
                               && !(pop && (PW'(gi) == head_q));
      end
   endgenerate

   always_comb begin
      coal_hit = 1'b0;
      coal_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (wr_match[age_idx[k]]) begin
            coal_hit = 1'b1;
            coal_idx = age_idx[k];
         end
      end
   end

   assign coalesce = clk_enable && i_write_enable && coal_hit;
`else
   assign coal_idx = '0;
   assign coalesce = 1'b0;
`endif

   assign push = clk_enable && i_write_enable && !coalesce && (!o_full || pop);

   always_comb begin
      valid_d    = valid_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PW'(1);
      end
      if (push) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (clk_enable && i_write_enable && o_full && !pop && !coalesce) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clk_enable) begin
         valid_q    <= valid_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Payload needs no reset: valid bits alone decide what is visible
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= i_write_address;
         data_q[tail_q] <= i_write_data;
      end else if (coalesce) begin
         data_q[coal_idx] <= i_write_data;
      end
   end

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized and directed bench for store_write_buffer against a queue-based reference model.
// Honours WB_COALESCE_EN the same way as the design.
module tb_store_write_buffer;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        clk_enable;
   logic        i_write_enable;
   logic [7:0]  i_write_address;
   logic [31:0] i_write_data;
   logic [7:0]  i_read_address;
   logic [31:0] o_read_data;
   logic        o_fwd_hit;
   logic        o_full;
   logic        o_empty;
   logic        o_overflow;
   logic [7:0]  o_mem_read_address;
   logic [31:0] i_mem_read_data;
   logic        o_mem_write_enable;
   logic [7:0]  o_mem_write_address;
   logic [31:0] o_mem_write_data;
   logic        i_mem_write_ready;

   store_write_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(32)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .clk_enable          (clk_enable),
      .i_write_enable      (i_write_enable),
      .i_write_address     (i_write_address),
      .i_write_data        (i_write_data),
      .i_read_address      (i_read_address),
      .o_read_data         (o_read_data),
      .o_fwd_hit           (o_fwd_hit),
      .o_full              (o_full),
      .o_empty             (o_empty),
      .o_overflow          (o_overflow),
      .o_mem_read_address  (o_mem_read_address),
      .i_mem_read_data     (i_mem_read_data),
      .o_mem_write_enable  (o_mem_write_enable),
      .o_mem_write_address (o_mem_write_address),
      .o_mem_write_data    (o_mem_write_data),
      .i_mem_write_ready   (i_mem_write_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: buffered stores oldest-first, sticky overflow, memory contents
   ent_t        mq[$];
   ent_t        exp_drain[$];
   ent_t        got_drain[$];
   bit          m_ovf;
   logic [31:0] mem [logic [7:0]];
   int          checks;
   int          errors;

   function automatic int m_find(input logic [7:0] a, input int lo);
      for (int i = mq.size() - 1; i >= lo; i--) begin
         if (mq[i].a == a) return i;
      end
      return -1;
   endfunction

   task automatic drive(input bit ce, input bit we, input logic [7:0] wa, input logic [31:0] wd,
                        input logic [7:0] ra, input bit rdy, input logic [31:0] mrd);
      clk_enable        = ce;
      i_write_enable    = we;
      i_write_address   = wa;
      i_write_data      = wd;
      i_read_address    = ra;
      i_mem_write_ready = rdy;
      i_mem_read_data   = mrd;
      #1;
   endtask

   // Log the DUT's drain for this cycle, cross the clock edge, then advance the model
   task automatic step();
      ent_t e;
      bit   pop;
      bit   full;
      int   ci;
      pop  = clk_enable && (mq.size() != 0) && i_mem_write_ready;
      full = (mq.size() == 4);
      if (rst_n && o_mem_write_enable && i_mem_write_ready) begin
         e.a = o_mem_write_address;
         e.d = o_mem_write_data;
         got_drain.push_back(e);
         mem[e.a] = e.d;
      end
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         ci = -1;
`ifdef WB_COALESCE_EN
         if (clk_enable && i_write_enable) ci = m_find(i_write_address, pop ? 1 : 0);
`endif
         if (ci >= 0) mq[ci].d = i_write_data;
         if (pop) begin
            exp_drain.push_back(mq[0]);
            mq.delete(0);
         end
         if (ci < 0 && clk_enable && i_write_enable) begin
            if (!full || pop) begin
               e.a = i_write_address;
               e.d = i_write_data;
               mq.push_back(e);
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h00, 1'b0, 32'h0);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      got_drain.delete();
      exp_drain.delete();
   endtask

   // Hold ready high until the buffer reports empty; returns 0 if it never does
   task automatic drain_all(input logic [7:0] ra, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         drive(1'b1, 1'b0, 8'h00, 32'h0, ra, 1'b1, 32'h0BAD_0000);
         if (o_empty) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      apply_reset();
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h55, 1'b1, 32'hDEADBEEF);
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", o_empty); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", o_full); end
      checks++; if (o_mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b exp 0", o_mem_write_enable); end
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", o_overflow); end
      checks++; if (o_mem_write_address !== 8'h00) begin errors++; $display("FAIL reset_waddr got %h exp 00", o_mem_write_address); end
      checks++; if (o_mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", o_mem_write_data); end
      checks++; if (o_fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit got %0b exp 0", o_fwd_hit); end
      checks++; if (o_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_rdata got %h exp deadbeef", o_read_data); end
      checks++; if (o_mem_read_address !== 8'h55) begin errors++; $display("FAIL reset_raddr got %h exp 55", o_mem_read_address); end
      $display("test_reset done");
   endtask

   task automatic test_fill_overflow();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 8'(8'h10 + i), 32'(i + 1), 8'hF0, 1'b0, $urandom);
         step();
      end
      drive(1'b1, 1'b1, 8'h20, 32'h99, 8'hF0, 1'b0, 32'h0);
      checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b exp 1", o_full); end
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %0b exp 0", o_overflow); end
      step();
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'hF0, 1'b0, 32'h0);
      checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %0b exp 1", o_overflow); end
      checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full_after got %0b exp 1", o_full); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'h00, 32'h0, 8'hF0, 1'b1, 32'h0);
         checks++; if (o_mem_write_enable !== 1'b1) begin errors++; $display("FAIL drain%0d_we got %0b exp 1", i, o_mem_write_enable); end
         checks++; if (o_mem_write_address !== 8'(8'h10 + i)) begin errors++; $display("FAIL drain%0d_addr got %h exp %h", i, o_mem_write_address, 8'(8'h10 + i)); end
         checks++; if (o_mem_write_data !== 32'(i + 1)) begin errors++; $display("FAIL drain%0d_data got %h exp %h", i, o_mem_write_data, 32'(i + 1)); end
         step();
      end
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'hF0, 1'b1, 32'h0);
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL fill_empty_end got %0b exp 1", o_empty); end
      checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf_sticky got %0b exp 1", o_overflow); end
      $display("test_fill_overflow done");
   endtask

   task automatic test_dup_forward();
      bit          ok;
      logic [31:0] mrd;
      apply_reset();
      drive(1'b1, 1'b1, 8'h40, 32'hA, 8'h00, 1'b0, 32'h0);
      step();
      drive(1'b1, 1'b1, 8'h40, 32'hB, 8'h00, 1'b0, 32'h0);
      step();
      mrd = $urandom;
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h40, 1'b0, mrd);
      checks++; if (o_fwd_hit !== 1'b1) begin errors++; $display("FAIL dup_fwd_hit got %0b exp 1", o_fwd_hit); end
      checks++; if (o_read_data !== 32'hB) begin errors++; $display("FAIL dup_fwd_data got %h exp 0000000b", o_read_data); end
      drain_all(8'h40, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dup_drain_timeout got %0b exp 1", ok); end
      mrd = $urandom;
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h40, 1'b1, mrd);
      checks++; if (o_fwd_hit !== 1'b0) begin errors++; $display("FAIL dup_after_hit got %0b exp 0", o_fwd_hit); end
      checks++; if (o_read_data !== mrd) begin errors++; $display("FAIL dup_after_data got %h exp %h", o_read_data, mrd); end
      checks++; if ((mem.exists(8'h40) ? mem[8'h40] : 32'hx) !== 32'hB) begin errors++; $display("FAIL dup_mem got %h exp 0000000b", mem.exists(8'h40) ? mem[8'h40] : 32'hx); end
      $display("test_dup_forward done");
   endtask

   task automatic test_back_to_back();
      ent_t pushed[$];
      ent_t e;
      bit   ok;
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         e.a = 8'(8'h80 + i);
         e.d = $urandom;
         pushed.push_back(e);
         drive(1'b1, 1'b1, e.a, e.d, 8'h00, (i >= 4), 32'h0);
         if (i >= 4) begin
            checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL b2b_full%0d got %0b exp 1", i, o_full); end
         end
         step();
      end
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h00, 1'b0, 32'h0);
      checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL b2b_full_end got %0b exp 1", o_full); end
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %0b exp 0", o_overflow); end
      drain_all(8'h00, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_drain_timeout got %0b exp 1", ok); end
      checks++; if (got_drain.size() !== 12) begin errors++; $display("FAIL b2b_count got %0d exp 12", got_drain.size()); end
      for (int i = 0; i < 12 && i < got_drain.size(); i++) begin
         checks++; if (got_drain[i] !== pushed[i]) begin errors++; $display("FAIL b2b_order%0d got %h exp %h", i, got_drain[i], pushed[i]); end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_clk_enable();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 8'(8'h60 + i), 32'(32'h600 + i), 8'h00, 1'b0, 32'h0);
         step();
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 8'h70, 32'h777, 8'h62, 1'b1, 32'h0);
         checks++; if (o_mem_write_enable !== 1'b0) begin errors++; $display("FAIL ce%0d_we got %0b exp 0", c, o_mem_write_enable); end
         checks++; if (o_mem_write_address !== 8'h60) begin errors++; $display("FAIL ce%0d_head got %h exp 60", c, o_mem_write_address); end
         checks++; if (o_read_data !== 32'h602) begin errors++; $display("FAIL ce%0d_fwd got %h exp 00000602", c, o_read_data); end
         step();
      end
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h70, 1'b1, 32'h0);
      checks++; if (o_fwd_hit !== 1'b0) begin errors++; $display("FAIL ce_no_push got %0b exp 0", o_fwd_hit); end
      checks++; if (o_mem_write_address !== 8'h60) begin errors++; $display("FAIL ce_resume_head got %h exp 60", o_mem_write_address); end
      step();
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h00, 1'b1, 32'h0);
      checks++; if (o_mem_write_address !== 8'h61) begin errors++; $display("FAIL ce_next_head got %h exp 61", o_mem_write_address); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h00, 1'b1, 32'h0);
         checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty%0d got %0b exp 1", c, o_empty); end
         checks++; if (o_mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_we%0d got %0b exp 0", c, o_mem_write_enable); end
         step();
      end
      checks++; if (got_drain.size() !== 1) begin errors++; $display("FAIL ce_drain_count got %0d exp 1", got_drain.size()); end
      $display("test_clk_enable done");
   endtask

`ifdef WB_COALESCE_EN
   task automatic test_coalesce();
      bit ok;
      apply_reset();
      drive(1'b1, 1'b1, 8'h40, 32'hA, 8'h00, 1'b0, 32'h0); step();
      drive(1'b1, 1'b1, 8'h41, 32'hC, 8'h00, 1'b0, 32'h0); step();
      drive(1'b1, 1'b1, 8'h40, 32'hB, 8'h00, 1'b0, 32'h0); step();
      drive(1'b1, 1'b0, 8'h00, 32'h0, 8'h40, 1'b0, 32'h0);
      checks++; if (o_read_data !== 32'hB) begin errors++; $display("FAIL coal_fwd got %h exp 0000000b", o_read_data); end
      drain_all(8'h00, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL coal_drain_timeout got %0b exp 1", ok); end
      checks++; if (got_drain.size() !== 2) begin errors++; $display("FAIL coal_count got %0d exp 2", got_drain.size()); end
      if (got_drain.size() == 2) begin
         checks++; if (got_drain[0] !== {8'h40, 32'hB}) begin errors++; $display("FAIL coal_first got %h exp 400000000b", got_drain[0]); end
         checks++; if (got_drain[1] !== {8'h41, 32'hC}) begin errors++; $display("FAIL coal_second got %h exp 410000000c", got_drain[1]); end
      end
      $display("test_coalesce done");
   endtask
`endif

   task automatic test_random();
      int          idx;
      bit          ok;
      logic [31:0] exp_rd;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)),
               $urandom, 8'($urandom_range(0, 7)), ($urandom_range(0, 4) < 3), $urandom);
         idx    = m_find(i_read_address, 0);
         exp_rd = (idx >= 0) ? mq[idx].d : i_mem_read_data;
         checks++; if (o_empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd%0d_empty got %0b exp %0b", c, o_empty, mq.size() == 0); end
         checks++; if (o_full !== (mq.size() == 4)) begin errors++; $display("FAIL rnd%0d_full got %0b exp %0b", c, o_full, mq.size() == 4); end
         checks++; if (o_overflow !== m_ovf) begin errors++; $display("FAIL rnd%0d_ovf got %0b exp %0b", c, o_overflow, m_ovf); end
         checks++; if (o_mem_write_enable !== (clk_enable && mq.size() != 0)) begin errors++; $display("FAIL rnd%0d_we got %0b exp %0b", c, o_mem_write_enable, clk_enable && mq.size() != 0); end
         checks++; if ({o_mem_write_address, o_mem_write_data} !== ((mq.size() != 0) ? mq[0] : 40'h0)) begin errors++; $display("FAIL rnd%0d_head got %h exp %h", c, {o_mem_write_address, o_mem_write_data}, (mq.size() != 0) ? mq[0] : 40'h0); end
         checks++; if (o_fwd_hit !== (idx >= 0)) begin errors++; $display("FAIL rnd%0d_hit got %0b exp %0b", c, o_fwd_hit, idx >= 0); end
         checks++; if (o_read_data !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", c, o_read_data, exp_rd); end
         step();
      end
      drain_all(8'h00, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_drain_timeout got %0b exp 1", ok); end
      checks++; if (got_drain.size() !== exp_drain.size()) begin errors++; $display("FAIL rnd_drain_count got %0d exp %0d", got_drain.size(), exp_drain.size()); end
      for (int i = 0; i < got_drain.size() && i < exp_drain.size(); i++) begin
         checks++; if (got_drain[i] !== exp_drain[i]) begin errors++; $display("FAIL rnd_drain%0d got %h exp %h", i, got_drain[i], exp_drain[i]); end
      end
      $display("test_random done: %0d drains", got_drain.size());
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_ovf  = 1'b0;
      rst_n  = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 32'h0, 8'h00, 1'b0, 32'h0);
      test_reset();
      test_fill_overflow();
      test_dup_forward();
      test_back_to_back();
      test_clk_enable();
`ifdef WB_COALESCE_EN
      test_coalesce();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
